// File: rtl/class_hv_streamer_pkg.sv
// Shared hypercorex definitions used by the class HV streamer and its buffer.
package class_hv_streamer_pkg;

  localparam int unsigned ExtendCountWidth = 5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StDrain = 2'd2
  } stream_state_e;

  // Number of dimension-extension steps actually run in one pass.
  function automatic logic [ExtendCountWidth-1:0] effective_steps(
    input logic                        enable,
    input logic [ExtendCountWidth-1:0] count
  );
    return (enable && (count != '0)) ? count : ExtendCountWidth'(1);
  endfunction

endpackage

// File: rtl/class_hv_streamer_fifo.sv
// Small synchronous FIFO holding class HVs returned by the class memory.
module fifo_buffer #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 512
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clear_i,
  input  logic                           wr_en_i,
  input  logic [Width-1:0]               wr_data_i,
  input  logic                           rd_en_i,
  output logic [Width-1:0]               rd_data_o,
  output logic                           empty_o,
  output logic                           full_o,
  output logic [$clog2(Depth+1)-1:0]     count_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);

  logic [Width-1:0]    mem_q [Depth];
  logic [PtrWidth-1:0] wr_ptr_q;
  logic [PtrWidth-1:0] rd_ptr_q;
  logic [CntWidth-1:0] count_q;
  logic                do_wr;
  logic                do_rd;

  // Guard pushes and pops against overflow and underflow.
  always_comb begin
    empty_o   = (count_q == '0);
    full_o    = (count_q == CntWidth'(Depth));
    do_wr     = wr_en_i && !full_o;
    do_rd     = rd_en_i && !empty_o;
    rd_data_o = mem_q[rd_ptr_q];
    count_o   = count_q;
  end

  // Storage, pointers and occupancy; clear flushes without touching storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q <= (wr_ptr_q == PtrWidth'(Depth - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
      end
      if (do_rd) begin
        rd_ptr_q <= (rd_ptr_q == PtrWidth'(Depth - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CntWidth'(1);
        2'b01:   count_q <= count_q - CntWidth'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/class_hv_streamer.sv
// Streams class hypervectors from the class memory to the associative memory,
// one read per class per extension step, with a 2-entry output buffer.
module class_hv_streamer
  import class_hv_streamer_pkg::*;
#(
  parameter int unsigned HVDimension  = 512,
  parameter int unsigned DataWidth    = 8,
  parameter int unsigned MemAddrWidth = 10
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic                        clear_i,
  input  logic [DataWidth-1:0]        num_class_i,
  input  logic                        extend_enable_i,
  input  logic [ExtendCountWidth-1:0] extend_count_i,
  input  logic [MemAddrWidth-1:0]     base_addr_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [MemAddrWidth-1:0]     mem_addr_o,
  output logic                        mem_ren_o,
  input  logic [HVDimension-1:0]      mem_rdata_i,
  output logic [HVDimension-1:0]      class_hv_o,
  output logic                        class_hv_valid_o,
  input  logic                        class_hv_ready_i
);

  localparam int unsigned CntWidth = DataWidth + ExtendCountWidth;

  stream_state_e         state_q;
  logic [CntWidth-1:0]   reads_left_q;
  logic [CntWidth-1:0]   xfers_left_q;
  logic [CntWidth-1:0]   total;
  logic [MemAddrWidth-1:0] rd_addr_q;
  logic [MemAddrWidth-1:0] last_addr_q;
  logic [MemAddrWidth-1:0] cur_addr;
  logic                  inflight_q;
  logic                  done_q;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [1:0]            fifo_count;
  logic [2:0]            occ_after_pop;
  logic                  pop;
  logic                  start_accept;
  logic                  issue;
  logic                  last_xfer;

  // Read issue and handshake decisions for the current cycle.
  // The first read goes out in the start cycle itself, and the occupancy test
  // credits this cycle's pop, so one HV per cycle is sustained with only two
  // buffer slots against the one-cycle memory latency.
  always_comb begin
    total         = CntWidth'(num_class_i) *
                    CntWidth'(effective_steps(extend_enable_i, extend_count_i));
    pop           = class_hv_valid_o && class_hv_ready_i;
    occ_after_pop = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
    start_accept  = (state_q == StIdle) && start_i && !clear_i;
    issue         = (start_accept && (total != '0)) ||
                    (!clear_i && (state_q == StFetch) && (reads_left_q != '0) &&
                     (occ_after_pop < 3'd2));
    cur_addr      = (state_q == StIdle) ? base_addr_i : rd_addr_q;
    last_xfer     = pop && (state_q == StDrain) && (xfers_left_q == CntWidth'(1));
    mem_ren_o     = issue;
    mem_addr_o    = issue ? cur_addr : last_addr_q;
    busy_o        = (state_q != StIdle);
    done_o        = done_q;
  end

  // Address bookkeeping: next read address and the last address presented.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_addr_q   <= '0;
      last_addr_q <= '0;
    end else if (issue) begin
      rd_addr_q   <= cur_addr + MemAddrWidth'(1);
      last_addr_q <= cur_addr;
    end
  end

  // Pass sequencing: IDLE -> FETCH -> DRAIN -> IDLE, with clear as abort.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      reads_left_q <= '0;
      xfers_left_q <= '0;
      inflight_q   <= 1'b0;
      done_q       <= 1'b0;
    end else if (clear_i) begin
      state_q      <= StIdle;
      reads_left_q <= '0;
      xfers_left_q <= '0;
      inflight_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            if (total == '0) begin
              done_q <= 1'b1;
            end else begin
              reads_left_q <= total - CntWidth'(1);
              xfers_left_q <= total;
              state_q      <= (total == CntWidth'(1)) ? StDrain : StFetch;
            end
          end
        end
        StFetch: begin
          if (pop) xfers_left_q <= xfers_left_q - CntWidth'(1);
          if (issue) begin
            reads_left_q <= reads_left_q - CntWidth'(1);
            if (reads_left_q == CntWidth'(1)) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (pop) xfers_left_q <= xfers_left_q - CntWidth'(1);
          if (last_xfer) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  fifo_buffer #(
    .Depth (2),
    .Width (HVDimension)
  ) u_fifo_buffer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (clear_i),
    .wr_en_i   (inflight_q),
    .wr_data_i (mem_rdata_i),
    .rd_en_i   (pop),
    .rd_data_o (class_hv_o),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .count_o   (fifo_count)
  );

  assign class_hv_valid_o = !fifo_empty;

endmodule
